fp32_matvec_issue: RTL

Operand sequencer that sits directly upstream of `fp32_mul` in the vertex transform path. It holds a 4x4 fp32 matrix and a 4-element fp32 vector, and on a start pulse streams the 16 product operand pairs M[r][c] × V[c] into the multiplier, one pair per cycle. Each pair carries a row/column tag so the downstream adder tree can reassemble the dot products. It does no arithmetic; it only stores, orders and paces operands.

---
 rtl/fp32_matvec_issue.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fp32_matvec_issue.sv
// fp32_matvec_issue
//
// Operand sequencer for fp32_mul in the vertex transform path. It stores a
// 4x4 fp32 matrix M and a 4-element fp32 vector V. On a start pulse it streams
// the 16 operand pairs M[r][c] x V[c] in row-major order, one pair per
// unstalled cycle. Each pair carries a {row, col} tag. It does no arithmetic.
//
// Ports
//   clk_in      system clock, rising edge
//   rst_in      synchronous active-low reset
//   wr_en_in    register-file write strobe (honoured in IDLE only)
//   wr_addr_in  0-15: M[addr>>2][addr&3], 16-19: V[addr-16], 20-31: ignored
//   wr_data_in  fp32 word to write
//   start_in    begin a 16-pair sequence
//   hold_in     downstream stall; no pair is issued on an edge where it is high
//   busy_out    sequence in progress
//   valid_out   a_out/b_out/idx_out carry a newly issued pair
//   a_out       matrix element
//   b_out       vector element
//   idx_out     {row[1:0], col[1:0]} tag of the current pair
//   last_out    high together with the pair at idx 15
//
// State table
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | operands writable, waiting for start_in
//   ST_ISSUE | issuing pairs cnt..15; operands frozen, start/writes dropped

module fp32_matvec_issue (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        wr_en_in,
    input  logic [4:0]  wr_addr_in,
    input  logic [31:0] wr_data_in,
    input  logic        start_in,
    input  logic        hold_in,
    output logic        busy_out,
    output logic        valid_out,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [3:0]  idx_out,
    output logic        last_out
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [0:0]  state;
    logic [3:0]  cnt;
    logic [31:0] m_reg [16];
    logic [31:0] v_reg [4];

    logic        seq_end;
    logic        start_ok;
    logic        issue_now;
    logic [3:0]  issue_idx;
    logic        wr_ok;

    // last_out is high exactly in the cycle after pair 15 was issued, so it
    // doubles as the "sequence ends at this edge" marker. That same edge may
    // accept a new start, which gives back-to-back sequences with no gap.
    always_comb begin
        seq_end   = 1'b0;
        start_ok  = 1'b0;
        issue_now = 1'b0;
        issue_idx = cnt;
        wr_ok     = 1'b0;

        seq_end  = (state == ST_ISSUE) && last_out;
        start_ok = start_in && ((state == ST_IDLE) || seq_end);

        if (start_ok) begin
            issue_idx = 4'd0;
            issue_now = !hold_in;
        end else if ((state == ST_ISSUE) && !seq_end) begin
            issue_now = !hold_in;
        end

        // start wins over a simultaneous write
        wr_ok = (state == ST_IDLE) && wr_en_in && !start_in;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            a_out     <= 32'd0;
            b_out     <= 32'd0;
            idx_out   <= 4'd0;
            for (int i = 0; i < 16; i++) begin
                m_reg[i] <= 32'd0;
            end
            for (int i = 0; i < 4; i++) begin
                v_reg[i] <= 32'd0;
            end
        end else begin
            if (start_ok) begin
                state <= ST_ISSUE;
            end else if (seq_end) begin
                state <= ST_IDLE;
            end

            if (issue_now) begin
                a_out     <= m_reg[issue_idx];
                b_out     <= v_reg[issue_idx[1:0]];
                idx_out   <= issue_idx;
                valid_out <= 1'b1;
                last_out  <= (issue_idx == 4'd15);
                cnt       <= issue_idx + 4'd1;
            end else begin
                // stalled or finishing: pair data stays frozen, only the
                // qualifiers drop
                valid_out <= 1'b0;
                last_out  <= 1'b0;
                if (start_ok || seq_end) begin
                    cnt <= 4'd0;
                end
            end

            if (wr_ok) begin
                if (!wr_addr_in[4]) begin
                    m_reg[wr_addr_in[3:0]] <= wr_data_in;
                end else if (wr_addr_in[3:2] == 2'b00) begin
                    v_reg[wr_addr_in[1:0]] <= wr_data_in;
                end
            end
        end
    end

    assign busy_out = (state == ST_ISSUE);

endmodule
